// File: rtl/mm2s_stream.sv
// mm2s_stream: result-drain engine for the matrix-multiply datapath.
// Accepts N-lane result words on a valid/ready port and buffers them in a
// small FIFO. Each word is then serialized lane by lane onto a 32-bit
// AXI-Stream master, and tlast is asserted on the final beat of the
// programmed transfer.
// Optional feature macro: MM2S_RELU_EN. When it is defined, negative lanes
// are clamped to zero and non-negative lanes are zero-extended. When it is
// undefined, lanes are sign-extended unchanged.
module mm2s_stream #(
  parameter int D_W          = 32,  // lane width, 1..32
  parameter int N            = 4,   // lanes per input word
  parameter int MATRIXSIZE_W = 16,  // width of the word-count input
  parameter int FIFO_DEPTH   = 4    // power of two, >= 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [MATRIXSIZE_W-1:0] num_words,
  input  logic [N*D_W-1:0]        in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [31:0]             m_axis_mm2s_tdata,
  output logic [3:0]              m_axis_mm2s_tkeep,
  output logic                    m_axis_mm2s_tlast,
  output logic                    m_axis_mm2s_tvalid,
  input  logic                    m_axis_mm2s_tready,
  output logic                    busy,
  output logic                    done
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int LANE_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DONE
  } state_t;

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  state_t                  r_state;
  logic [MATRIXSIZE_W-1:0] r_num_words;
  logic [MATRIXSIZE_W-1:0] r_words_accepted;
  logic [MATRIXSIZE_W-1:0] r_words_sent;
  logic                    r_busy;
  logic                    r_done;

  logic [N*D_W-1:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [AW:0]             r_count;

  logic [LANE_W-1:0]       r_lane_idx;
  logic                    r_tvalid;
  logic                    r_tlast;
  logic [31:0]             r_tdata;

  // ---------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_in_ready;
  logic             w_wr;
  logic             w_hs;
  logic             w_load;
  logic             w_last_lane;
  logic             w_last_word;
  logic             w_pop;
  logic [N*D_W-1:0] w_head;
  logic [D_W-1:0]   w_lane;
  logic [31:0]      w_beat_data;

  assign w_fifo_full  = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_fifo_empty = (r_count == '0);

  // Occupancy is registered, so a full FIFO refuses input even on a pop cycle.
  assign w_in_ready = (r_state == ST_STREAM) && !w_fifo_full &&
                      (r_words_accepted < r_num_words);
  assign w_wr       = in_valid && w_in_ready;

  assign w_hs        = r_tvalid && m_axis_mm2s_tready;
  // The beat register refills when it is empty or when its beat is leaving.
  assign w_load      = (r_state == ST_STREAM) && !w_fifo_empty &&
                       (!r_tvalid || m_axis_mm2s_tready);
  assign w_last_lane = (r_lane_idx == LANE_W'(N - 1));
  assign w_last_word = (r_words_sent == (r_num_words - MATRIXSIZE_W'(1)));
  assign w_pop       = w_load && w_last_lane;
  assign w_head      = r_mem[r_rd_ptr];

  // Select the current lane of the FIFO head word.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_lane = w_head[D_W-1:0];
    for (int i = 0; i < N; i++) begin
      if (r_lane_idx == LANE_W'(i)) w_lane = w_head[i*D_W +: D_W];
    end
  end

  // Widen the selected lane to the 32-bit stream word.
  always_comb begin
`ifdef MM2S_RELU_EN
    w_beat_data = w_lane[D_W-1] ? 32'h0 : 32'(w_lane);
`else
    w_beat_data = 32'($signed(w_lane));
`endif
  end

  // ---------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------
  // Storage write port.
  // NOTE: the storage array has no reset; the pointers and count alone decide validity.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= in_data;
  end

  // Pointer and occupancy bookkeeping; a write and a pop in one cycle cancel out.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Transfer FSM with registered busy/done
  // ---------------------------------------------------------------------
  // Sequence IDLE -> STREAM -> DONE -> IDLE and count the accepted and drained words.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_num_words      <= '0;
      r_words_accepted <= '0;
      r_words_sent     <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_num_words      <= num_words;
            r_words_accepted <= '0;
            r_words_sent     <= '0;
            r_busy           <= 1'b1;
            if (num_words != '0) begin
              r_state <= ST_STREAM;
            end else begin
              // An empty transfer completes without emitting any beat.
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (w_wr)  r_words_accepted <= r_words_accepted + MATRIXSIZE_W'(1);
          if (w_pop) r_words_sent     <= r_words_sent + MATRIXSIZE_W'(1);
          if (w_hs && r_tlast) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Output beat register
  // ---------------------------------------------------------------------
  // Hold the beat until it is accepted, and refill it from the next lane in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
      r_tdata    <= '0;
      r_lane_idx <= '0;
    end else if (w_load) begin
      r_tvalid   <= 1'b1;
      r_tdata    <= w_beat_data;
      r_tlast    <= w_last_lane && w_last_word;
      r_lane_idx <= w_last_lane ? '0 : r_lane_idx + LANE_W'(1);
    end else if (w_hs) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end
  end

  assign in_ready           = w_in_ready;
  assign m_axis_mm2s_tdata  = r_tdata;
  assign m_axis_mm2s_tkeep  = 4'hF;
  assign m_axis_mm2s_tlast  = r_tlast;
  assign m_axis_mm2s_tvalid = r_tvalid;
  assign busy               = r_busy;
  assign done               = r_done;

endmodule
